// File: rtl/masked_sign_seq.sv
// rtl/masked_sign_seq.sv - sequencing controller for the masked sign/step activation datapath
module masked_sign_seq #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_mask1,
  input  logic [WIDTH-1:0] in_mask2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DATA_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [WIDTH-1:0] unmasked;
  logic [WIDTH-1:0] result;
  logic             in_hs;
  logic             out_hs;
  logic             last_in;
  logic             last_out;

  // Non-negative unmasked value maps to step=1, which in the masked domain is mask2+1.
  assign unmasked = in_data + in_mask1;
  assign result   = unmasked[WIDTH-1] ? in_mask2 : in_mask2 + DATA_ONE;

  assign in_ready = (state == S_RUN) && (in_cnt < len) && (!out_valid || out_ready);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign last_in  = (in_cnt == len - CNT_ONE);
  assign last_out = (out_idx == len - CNT_ONE) && (out_cnt == len - CNT_ONE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len       <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_len == '0) begin
              done <= 1'b1;
            end else begin
              len     <= cfg_len;
              in_cnt  <= '0;
              out_cnt <= '0;
              state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (in_hs && last_in) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_hs && last_out) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Single-entry output register: a same-edge accept reloads it instead of emptying it.
      if (in_hs) begin
        out_data  <= result;
        out_idx   <= in_cnt;
        out_valid <= 1'b1;
        in_cnt    <= in_cnt + CNT_ONE;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
      if (out_hs) out_cnt <= out_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_masked_sign_seq.sv
// tb/tb_masked_sign_seq.sv - scoreboard bench for masked_sign_seq
module tb_masked_sign_seq;
  localparam int W  = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [W-1:0]  in_mask1 = '0;
  logic [W-1:0]  in_mask2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_idx;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [CW-1:0] idx;
    logic [W-1:0]  data;
  } exp_t;
  exp_t sb[$];

  logic [W-1:0] ed[16];
  logic [W-1:0] em1[16];
  logic [W-1:0] em2[16];

  masked_sign_seq #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mask1(in_mask1), .in_mask2(in_mask2), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [W-1:0] m1,
                                         input logic [W-1:0] m2);
    logic [W-1:0] u;
    u = d + m1;
    return (u[W-1] == 1'b0) ? m2 + 64'd1 : m2;
  endfunction

  // mode 0: out_ready high; 1: ready 1,0,0 pattern; 2: random valid/ready
  task automatic run_vec(input int n, input int mode, input int ign_len, input int abort_at);
    int   sent = 0;
    int   got = 0;
    int   cyc = 0;
    bit   done_exp = 0;
    bit   prev_stall = 0;
    bit   fin = 0;
    logic [W-1:0]  pd = '0;
    logic [CW-1:0] pi = '0;
    exp_t e;
    start = 1'b1;
    cfg_len = n[CW-1:0];
    @(posedge clk); #1;
    start = 1'b0;
    while (!fin && cyc < 200) begin
      start = (ign_len > 0 && cyc == 1);
      if (start) cfg_len = ign_len[CW-1:0];
      in_valid = (sent < n) && (mode != 2 || $urandom_range(0, 1) == 1);
      if (sent < n) begin
        in_data  = ed[sent];
        in_mask1 = em1[sent];
        in_mask2 = em2[sent];
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      @(negedge clk);
      check("done", done, done_exp);
      if (done_exp) begin
        check("busy_off", busy, 0);
        check("ov_off", out_valid, 0);
        check("sb_empty", sb.size(), 0);
        if (mode == 0) check("latency", cyc, n + 1);
        fin = 1;
      end else begin
        check("busy", busy, 1);
        if (prev_stall) begin
          check("hold_data", out_data, pd);
          check("hold_idx", out_idx, pi);
        end
        if (out_valid && !out_ready) check("rdy_stall", in_ready, 0);
        if (sent == n) check("rdy_full", in_ready, 0);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("extra_out", 1, 0);
          end else begin
            e = sb.pop_front();
            check("out_data", out_data, e.data);
            check("out_idx", out_idx, e.idx);
          end
          got++;
          done_exp = (got == n);
        end
        if (in_valid && in_ready) begin
          e.idx  = sent[CW-1:0];
          e.data = model(in_data, in_mask1, in_mask2);
          sb.push_back(e);
          sent++;
        end
        prev_stall = out_valid && !out_ready;
        pd = out_data;
        pi = out_idx;
        if (abort_at > 0 && got == abort_at) fin = 1;
      end
      cyc++;
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    if (!fin) check("timeout", 0, 1);
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;

    ed[0] = 64'd5; em1[0] = 64'd3; em2[0] = 64'd100;
    run_vec(1, 0, 0, 0);

    ed[0] = 64'hFFFF_FFFF_FFFF_FFFF; em1[0] = 64'd0;                  em2[0] = 64'd7;
    ed[1] = 64'h8000_0000_0000_0000; em1[1] = 64'h8000_0000_0000_0000; em2[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_vec(2, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      ed[i]  = {$urandom, $urandom};
      em1[i] = {$urandom, $urandom};
      em2[i] = (i % 4 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
    end
    run_vec(8, 0, 0, 0);
    run_vec(4, 1, 0, 0);

    start = 1'b1;
    cfg_len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zl_done", done, 1);
    check("zl_busy", busy, 0);
    check("zl_out_valid", out_valid, 0);
    run_vec(3, 0, 0, 0);

    run_vec(5, 2, 9, 0);

    run_vec(5, 0, 0, 2);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ab_out_valid", out_valid, 0);
    check("ab_out_data", out_data, 0);
    check("ab_out_idx", out_idx, 0);
    check("ab_busy", busy, 0);
    check("ab_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      check("ab_done", done, 0);
      @(negedge clk);
    end
    sb.delete();
    run_vec(3, 1, 0, 0);

    run_vec(12, 2, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
